// File: rtl/mmu_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : mmu_feeder
//  Description : Operand sequencer and result drain for a 2x2 output-stationary
//                systolic matrix-multiply unit. Presents A rows and B columns
//                with diagonal skew and drives the accumulator clear. Serialises
//                the four results to the host port, one byte per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmu_feeder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] mmu_cycles,
    input  logic [7:0] weight_0,
    input  logic [7:0] weight_1,
    input  logic [7:0] weight_2,
    input  logic [7:0] weight_3,
    input  logic [7:0] input_0,
    input  logic [7:0] input_1,
    input  logic [7:0] input_2,
    input  logic [7:0] input_3,
    input  logic [7:0] c_0,
    input  logic [7:0] c_1,
    input  logic [7:0] c_2,
    input  logic [7:0] c_3,
    output logic       clear,
    output logic [7:0] a_data0,
    output logic [7:0] a_data1,
    output logic [7:0] b_data0,
    output logic [7:0] b_data1,
    output logic       host_mat_wb,
    output logic [7:0] host_outdata
);

    // Step indices within a job
    localparam logic [2:0] STEP_FEED0  = 3'd0;
    localparam logic [2:0] STEP_FEED1  = 3'd1;
    localparam logic [2:0] STEP_FEED2  = 3'd2;
    localparam logic [2:0] STEP_DRAIN0 = 3'd3;
    localparam logic [2:0] STEP_DRAIN1 = 3'd4;
    localparam logic [2:0] STEP_DRAIN2 = 3'd5;
    localparam logic [2:0] STEP_DRAIN3 = 3'd6;
    localparam logic [2:0] STEP_CLEAR  = 3'd7;

    logic       w_active;
    logic       host_mat_wb_q;
    logic       host_mat_wb_d;
    logic [7:0] host_outdata_q;
    logic [7:0] host_outdata_d;

    // The feeder only does anything while out of reset and enabled
    assign w_active = rst_n & en;

    // Skewed operand presentation; lanes not used at a step stay at zero
    // so the array never accumulates stray products.
    always_comb begin
        clear   = 1'b1;
        a_data0 = 8'd0;
        a_data1 = 8'd0;
        b_data0 = 8'd0;
        b_data1 = 8'd0;
        if (w_active) begin
            clear = 1'b0;
            case (mmu_cycles)
                STEP_FEED0: begin
                    a_data0 = input_0;   // A00
                    b_data0 = weight_0;  // B00
                end
                STEP_FEED1: begin
                    a_data0 = input_1;   // A01
                    a_data1 = input_2;   // A10
                    b_data0 = weight_2;  // B10
                    b_data1 = weight_1;  // B01
                end
                STEP_FEED2: begin
                    a_data1 = input_3;   // A11
                    b_data1 = weight_3;  // B11
                end
                // Clear at the final step so a job restarting at step 0
                // begins from zeroed accumulators.
                STEP_CLEAR: clear = 1'b1;
                default: ;
            endcase
        end
    end

    // Select which result byte to capture during the drain window
    always_comb begin
        host_mat_wb_d  = 1'b0;
        host_outdata_d = 8'd0;
        if (w_active) begin
            case (mmu_cycles)
                STEP_DRAIN0: begin host_mat_wb_d = 1'b1; host_outdata_d = c_0; end
                STEP_DRAIN1: begin host_mat_wb_d = 1'b1; host_outdata_d = c_1; end
                STEP_DRAIN2: begin host_mat_wb_d = 1'b1; host_outdata_d = c_2; end
                STEP_DRAIN3: begin host_mat_wb_d = 1'b1; host_outdata_d = c_3; end
                default: ;
            endcase
        end
    end

    // Host port registers; cleared synchronously while rst_n is low
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            host_mat_wb_q  <= 1'b0;
            host_outdata_q <= 8'd0;
        end else begin
            host_mat_wb_q  <= host_mat_wb_d;
            host_outdata_q <= host_outdata_d;
        end
    end

    assign host_mat_wb  = host_mat_wb_q;
    assign host_outdata = host_outdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mmu_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmu_feeder
//  Description : Self-checking bench for mmu_feeder with a behavioural 2x2
//                output-stationary systolic array attached.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmu_feeder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [2:0] mmu_cycles;
    logic [7:0] a_m [4];
    logic [7:0] b_m [4];
    logic [7:0] c_drv [4];
    logic       use_model;
    logic [7:0] c_0, c_1, c_2, c_3;
    logic       clear;
    logic [7:0] a_data0, a_data1, b_data0, b_data1;
    logic       host_mat_wb;
    logic [7:0] host_outdata;

    // Systolic array model state
    logic [7:0] acc00 = 8'd0, acc01 = 8'd0, acc10 = 8'd0, acc11 = 8'd0;
    logic [7:0] ar00 = 8'd0, ar10 = 8'd0, bd00 = 8'd0, bd01 = 8'd0;
    logic [15:0] p00, p01, p10, p11;

    always #5 clk = ~clk;

    mmu_feeder dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mmu_cycles(mmu_cycles),
        .weight_0(b_m[0]), .weight_1(b_m[1]), .weight_2(b_m[2]), .weight_3(b_m[3]),
        .input_0(a_m[0]), .input_1(a_m[1]), .input_2(a_m[2]), .input_3(a_m[3]),
        .c_0(c_0), .c_1(c_1), .c_2(c_2), .c_3(c_3),
        .clear(clear),
        .a_data0(a_data0), .a_data1(a_data1), .b_data0(b_data0), .b_data1(b_data1),
        .host_mat_wb(host_mat_wb), .host_outdata(host_outdata)
    );

    assign c_0 = use_model ? acc00 : c_drv[0];
    assign c_1 = use_model ? acc01 : c_drv[1];
    assign c_2 = use_model ? acc10 : c_drv[2];
    assign c_3 = use_model ? acc11 : c_drv[3];

    assign p00 = a_data0 * b_data0;
    assign p01 = ar00 * b_data1;
    assign p10 = a_data1 * bd00;
    assign p11 = ar10 * bd01;

    // A flows right, B flows down, each PE accumulates in place
    always @(posedge clk) begin
        if (clear) begin
            acc00 <= 8'd0; acc01 <= 8'd0; acc10 <= 8'd0; acc11 <= 8'd0;
            ar00 <= 8'd0; ar10 <= 8'd0; bd00 <= 8'd0; bd01 <= 8'd0;
        end else begin
            acc00 <= acc00 + p00[7:0];
            acc01 <= acc01 + p01[7:0];
            acc10 <= acc10 + p10[7:0];
            acc11 <= acc11 + p11[7:0];
            ar00  <= a_data0;
            ar10  <= a_data1;
            bd00  <= b_data0;
            bd01  <= b_data1;
        end
    end

    // ---------------- checking infrastructure ----------------
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit         wb;
        logic [7:0] d;
    } drain_t;
    drain_t     sb [$];
    logic [7:0] got [$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one step and queue the host-port result expected after the edge
    task automatic apply(input logic r, input logic e, input logic [2:0] cyc);
        drain_t x;
        rst_n      = r;
        en         = e;
        mmu_cycles = cyc;
        #1;
        x.wb = 1'b0;
        x.d  = 8'd0;
        if (r && e && cyc >= 3'd3 && cyc <= 3'd6) begin
            x.wb = 1'b1;
            case (cyc)
                3'd3:    x.d = c_0;
                3'd4:    x.d = c_1;
                3'd5:    x.d = c_2;
                default: x.d = c_3;
            endcase
        end
        sb.push_back(x);
    endtask

    // Clock edge, then pop the scoreboard and compare the host port
    task automatic tick();
        drain_t x;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            x = sb.pop_front();
            chk("host_mat_wb", int'(host_mat_wb), int'(x.wb));
            chk("host_outdata", int'(host_outdata), int'(x.d));
        end
        if (host_mat_wb === 1'b1) got.push_back(host_outdata);
    endtask

    task automatic chk_lanes(input string tag, input int clr, input int a0, input int a1,
                             input int b0, input int b1);
        chk({tag, "_clear"}, int'(clear), clr);
        chk({tag, "_a0"}, int'(a_data0), a0);
        chk({tag, "_a1"}, int'(a_data1), a1);
        chk({tag, "_b0"}, int'(b_data0), b0);
        chk({tag, "_b1"}, int'(b_data1), b1);
    endtask

    task automatic load(input int a0, input int a1, input int a2, input int a3,
                        input int b0, input int b1, input int b2, input int b3);
        a_m[0] = 8'(a0); a_m[1] = 8'(a1); a_m[2] = 8'(a2); a_m[3] = 8'(a3);
        b_m[0] = 8'(b0); b_m[1] = 8'(b1); b_m[2] = 8'(b2); b_m[3] = 8'(b3);
    endtask

    // Run steps 0..7 with the array attached and check the four strobes
    task automatic run_job(input string tag);
        int r [4];
        got.delete();
        for (int s = 0; s < 8; s++) begin
            apply(1'b1, 1'b1, 3'(s));
            tick();
        end
        r[0] = (a_m[0] * b_m[0] + a_m[1] * b_m[2]) & 255;
        r[1] = (a_m[0] * b_m[1] + a_m[1] * b_m[3]) & 255;
        r[2] = (a_m[2] * b_m[0] + a_m[3] * b_m[2]) & 255;
        r[3] = (a_m[2] * b_m[1] + a_m[3] * b_m[3]) & 255;
        chk({tag, "_strobes"}, got.size(), 4);
        for (int k = 0; k < 4; k++)
            chk({tag, "_c", $sformatf("%0d", k)}, (k < got.size()) ? int'(got[k]) : -1, r[k]);
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        logic       r;
        logic       e;
        logic [2:0] cyc;
        int         clr, a0, a1, b0, b1;
    } vec_t;
    vec_t vecs [13];

    initial begin
        rst_n = 1'b0; en = 1'b0; mmu_cycles = 3'd0; use_model = 1'b0;
        load(1, 2, 3, 4, 5, 6, 7, 8);
        c_drv[0] = 8'd19; c_drv[1] = 8'd22; c_drv[2] = 8'd43; c_drv[3] = 8'd50;

        //          r     e     cyc   clr a0 a1 b0 b1
        vecs[0]  = '{1'b0, 1'b1, 3'd3, 1, 0, 0, 0, 0};
        vecs[1]  = '{1'b0, 1'b1, 3'd3, 1, 0, 0, 0, 0};
        vecs[2]  = '{1'b1, 1'b1, 3'd0, 0, 1, 0, 5, 0};
        vecs[3]  = '{1'b1, 1'b1, 3'd1, 0, 2, 3, 7, 6};
        vecs[4]  = '{1'b1, 1'b1, 3'd2, 0, 0, 4, 0, 8};
        vecs[5]  = '{1'b1, 1'b1, 3'd3, 0, 0, 0, 0, 0};
        vecs[6]  = '{1'b1, 1'b1, 3'd4, 0, 0, 0, 0, 0};
        vecs[7]  = '{1'b1, 1'b1, 3'd5, 0, 0, 0, 0, 0};
        vecs[8]  = '{1'b1, 1'b1, 3'd6, 0, 0, 0, 0, 0};
        vecs[9]  = '{1'b1, 1'b1, 3'd7, 1, 0, 0, 0, 0};
        vecs[10] = '{1'b1, 1'b1, 3'd4, 0, 0, 0, 0, 0};
        vecs[11] = '{1'b1, 1'b1, 3'd4, 0, 0, 0, 0, 0};
        vecs[12] = '{1'b1, 1'b0, 3'd1, 1, 0, 0, 0, 0};

        // Table: reset, feed skew, drain, held step, en low
        for (int i = 0; i < 13; i++) begin
            apply(vecs[i].r, vecs[i].e, vecs[i].cyc);
            chk_lanes($sformatf("vec%0d", i), vecs[i].clr, vecs[i].a0, vecs[i].a1,
                      vecs[i].b0, vecs[i].b1);
            tick();
        end

        // Fixed drain values independent of the scoreboard's sampling
        got.delete();
        for (int s = 3; s < 8; s++) begin
            apply(1'b1, 1'b1, 3'(s));
            tick();
        end
        chk("drain_cnt", got.size(), 4);
        if (got.size() == 4) begin
            chk("drain0", int'(got[0]), 19);
            chk("drain1", int'(got[1]), 22);
            chk("drain2", int'(got[2]), 43);
            chk("drain3", int'(got[3]), 50);
        end
        chk("drain_end_clear", int'(clear), 1);

        // Full job with the array model attached
        use_model = 1'b1;
        apply(1'b1, 1'b0, 3'd0);
        tick();
        run_job("job1");

        // en dropped at step 4: feeding stops at once, strobes lost
        load(2, 3, 5, 7, 1, 4, 6, 9);
        for (int s = 0; s < 4; s++) begin
            apply(1'b1, 1'b1, 3'(s));
            tick();
        end
        apply(1'b1, 1'b0, 3'd4);
        chk_lanes("endrop", 1, 0, 0, 0, 0);
        tick();
        chk("endrop_wb", int'(host_mat_wb), 0);
        run_job("rerun");

        // Back-to-back jobs across the 7->0 wrap
        load(1, 2, 3, 4, 5, 6, 7, 8);
        run_job("b2b1");
        load(1, 0, 0, 1, 9, 8, 7, 6);
        run_job("b2b2");
        if (got.size() == 4) begin
            chk("b2b2_v0", int'(got[0]), 9);
            chk("b2b2_v1", int'(got[1]), 8);
            chk("b2b2_v2", int'(got[2]), 7);
            chk("b2b2_v3", int'(got[3]), 6);
        end else begin
            chk("b2b2_cnt", got.size(), 4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
